// File: rtl/remote_controller_rx.sv
// Serial remote-control receiver: deframes start + custom + key + ~key, validates it,
// optionally filters by custom code and tracks repeated presses inside a time window.
//   state | meaning
//   IDLE  | line idle, waiting for a low start bit
//   DATA  | shifting FRAME_W bits MSB first, then one settle cycle
//   CHECK | validate frame, update outputs and repeat tracking
//   STOP  | wait for the line to return high
module remote_controller_rx #(
    parameter int                CUSTOM_W   = 16,
    parameter int                KEY_W      = 8,
    parameter int                FILTER_EN  = 0,
    parameter logic [CUSTOM_W-1:0] CUSTOM_ID = {CUSTOM_W{1'b1}},
    parameter int                REPEAT_WIN = 64,
    parameter int                CNT_W      = 8
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Serial,
    output logic [KEY_W-1:0]    Tecla,
    output logic [CUSTOM_W-1:0] Custom,
    output logic                Ready,
    output logic                Error,
    output logic                Repeat,
    output logic [CNT_W-1:0]    RepeatCount
);

    localparam int FRAME_W = CUSTOM_W + 2*KEY_W;
    localparam int BCW     = $clog2(FRAME_W + 1);
    localparam int WW      = $clog2(REPEAT_WIN + 1);

    typedef enum logic [1:0] {IDLE, DATA, CHECK, STOP} state_t;

    state_t              state;
    logic [FRAME_W-1:0]  shreg;
    logic [BCW-1:0]      bit_cnt;
    logic [WW-1:0]       win_cnt;
    logic [KEY_W-1:0]    last_key;
    logic [CUSTOM_W-1:0] last_custom;

    logic [CUSTOM_W-1:0] fr_custom;
    logic [KEY_W-1:0]    fr_key;
    logic [KEY_W-1:0]    fr_inv;
    logic                frame_ok;
    logic                is_rep;

    assign fr_custom = shreg[FRAME_W-1 -: CUSTOM_W];
    assign fr_key    = shreg[2*KEY_W-1 -: KEY_W];
    assign fr_inv    = shreg[KEY_W-1:0];
    assign frame_ok  = (fr_key == ~fr_inv) && ((FILTER_EN == 0) || (fr_custom == CUSTOM_ID));
    // A nonzero window implies a valid frame was recorded since reset.
    assign is_rep    = (win_cnt != '0) && (fr_key == last_key) && (fr_custom == last_custom);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            win_cnt     <= '0;
            last_key    <= '0;
            last_custom <= '0;
            Tecla       <= '0;
            Custom      <= '0;
            Ready       <= 1'b0;
            Error       <= 1'b0;
            Repeat      <= 1'b0;
            RepeatCount <= '0;
        end else begin
            Error <= 1'b0;
            if (win_cnt != '0)
                win_cnt <= win_cnt - 1'b1;
            case (state)
                IDLE: begin
                    if (!Serial) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        Ready   <= 1'b0;
                        Repeat  <= 1'b0;
                    end
                end
                DATA: begin
                    // Counter reaching FRAME_W gives one settle cycle before CHECK.
                    if (bit_cnt == BCW'(FRAME_W)) begin
                        state <= CHECK;
                    end else begin
                        shreg   <= {shreg[FRAME_W-2:0], Serial};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (frame_ok) begin
                        Tecla       <= fr_key;
                        Custom      <= fr_custom;
                        Ready       <= 1'b1;
                        Repeat      <= is_rep;
                        if (!is_rep)
                            RepeatCount <= '0;
                        else if (!(&RepeatCount))
                            RepeatCount <= RepeatCount + 1'b1;
                        last_key    <= fr_key;
                        last_custom <= fr_custom;
                        win_cnt     <= WW'(REPEAT_WIN);
                    end else begin
                        Error <= 1'b1;
                    end
                    state <= STOP;
                end
                STOP: begin
                    if (Serial)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_remote_controller_rx.sv
// Bench for remote_controller_rx: default, filtered and narrow-field instances,
// directed frames plus random frames checked against a time-based reference model.
module tb_remote_controller_rx;

    logic clk = 1'b0;
    logic rst;
    logic ser0, ser1, ser2;

    logic [7:0]  t0;  logic [15:0] c0; logic r0, e0, p0; logic [7:0] n0;
    logic [7:0]  t1;  logic [15:0] c1; logic r1, e1, p1; logic [7:0] n1;
    logic [3:0]  t2;  logic [7:0]  c2; logic r2, e2, p2; logic [7:0] n2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // reference model state for the default instance
    logic [7:0]  m_tecla, m_lkey;
    logic [15:0] m_cus, m_lcus;
    logic        m_ready, m_rep, m_have;
    int          m_cnt;
    int          m_rise;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    remote_controller_rx dut0 (
        .Clock(clk), .Reset(rst), .Serial(ser0), .Tecla(t0), .Custom(c0),
        .Ready(r0), .Error(e0), .Repeat(p0), .RepeatCount(n0)
    );

    remote_controller_rx #(.FILTER_EN(1), .CUSTOM_ID(16'h00FF)) dut1 (
        .Clock(clk), .Reset(rst), .Serial(ser1), .Tecla(t1), .Custom(c1),
        .Ready(r1), .Error(e1), .Repeat(p1), .RepeatCount(n1)
    );

    remote_controller_rx #(.CUSTOM_W(8), .KEY_W(4), .CUSTOM_ID(8'hFF)) dut2 (
        .Clock(clk), .Reset(rst), .Serial(ser2), .Tecla(t2), .Custom(c2),
        .Ready(r2), .Error(e2), .Repeat(p2), .RepeatCount(n2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic b);
        case (sel)
            0:       ser0 = b;
            1:       ser1 = b;
            default: ser2 = b;
        endcase
    endtask

    // returns between the last-bit edge and the following edge
    task automatic send(input int sel, input logic [31:0] frame, input int len);
        @(negedge clk); drive(sel, 1'b0);
        for (int i = len - 1; i >= 0; i--) begin
            @(negedge clk); drive(sel, frame[i]);
        end
        @(negedge clk); drive(sel, 1'b1);
    endtask

    task automatic model_reset();
        m_tecla = '0; m_cus = '0; m_ready = 1'b0; m_rep = 1'b0;
        m_cnt = 0; m_have = 1'b0; m_lkey = '0; m_lcus = '0; m_rise = 0;
    endtask

    task automatic run0(input logic [15:0] c, input logic [7:0] k, input logic [7:0] ik, input int gap);
        logic valid, rep;
        send(0, {c, k, ik}, 32);
        @(negedge clk);
        chk("ready_before_check", 32'(r0), 32'(0));
        @(negedge clk);
        valid = (k == ~ik);
        if (valid) begin
            rep = m_have && (k == m_lkey) && (c == m_lcus) && ((cyc - m_rise) <= 64);
            m_cnt   = rep ? ((m_cnt == 255) ? 255 : m_cnt + 1) : 0;
            m_rep   = rep;
            m_ready = 1'b1;
            m_tecla = k;
            m_cus   = c;
            m_have  = 1'b1;
            m_lkey  = k;
            m_lcus  = c;
            m_rise  = cyc;
        end else begin
            m_ready = 1'b0;
            m_rep   = 1'b0;
        end
        chk("tecla", 32'(t0), 32'(m_tecla));
        chk("custom", 32'(c0), 32'(m_cus));
        chk("ready", 32'(r0), 32'(m_ready));
        chk("error", 32'(e0), 32'(!valid));
        chk("repeat", 32'(p0), 32'(m_rep));
        chk("repeat_count", 32'(n0), 32'(m_cnt));
        @(negedge clk);
        chk("error_one_cycle", 32'(e0), 32'(0));
        chk("ready_hold", 32'(r0), 32'(m_ready));
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        logic [7:0]  keys [8];
        logic [7:0]  k, ik;
        logic [15:0] c;
        keys = '{8'h00, 8'h01, 8'h1A, 8'hB2, 8'hFF, 8'h55, 8'hAA, 8'hC3};
        rst = 1'b1; ser0 = 1'b1; ser1 = 1'b1; ser2 = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_tecla", 32'(t0), 32'(0));
        chk("reset_custom", 32'(c0), 32'(0));
        chk("reset_ready", 32'(r0), 32'(0));
        chk("reset_error", 32'(e0), 32'(0));
        chk("reset_repeat", 32'(p0), 32'(0));
        chk("reset_count", 32'(n0), 32'(0));

        for (int i = 0; i < 8; i++)
            run0(16'hFFFF, keys[i], ~keys[i], 20);

        // all-ones frame: key FF with inverted FF is rejected
        run0(16'hFFFF, 8'hFF, 8'hFF, 5);
        chk("tecla_kept_after_error", 32'(t0), 32'(8'hC3));

        run0(16'hFFFF, 8'h1A, 8'hE5, 0);
        run0(16'hFFFF, 8'h1A, 8'hE5, 0);
        run0(16'hFFFF, 8'h1A, 8'hE5, 100);
        run0(16'hFFFF, 8'h1A, 8'hE5, 0);

        // window edge: gap 27 is the last one still inside the repeat window
        run0(16'hFFFF, 8'h55, 8'hAA, 27);
        run0(16'hFFFF, 8'h55, 8'hAA, 28);
        run0(16'hFFFF, 8'h55, 8'hAA, 0);

        for (int i = 0; i < 40; i++) begin
            k  = ($urandom_range(0, 1) == 1) ? m_lkey : 8'($urandom);
            c  = ($urandom_range(0, 3) == 0) ? 16'h1234 : 16'hFFFF;
            ik = ~k;
            if ($urandom_range(0, 4) == 0)
                ik = ik ^ 8'($urandom_range(1, 255));
            run0(c, k, ik, $urandom_range(0, 40));
        end

        send(1, {16'h00FF, 8'h33, 8'hCC}, 32);
        repeat (2) @(negedge clk);
        chk("filt_ready", 32'(r1), 32'(1));
        chk("filt_tecla", 32'(t1), 32'(8'h33));
        chk("filt_error", 32'(e1), 32'(0));
        repeat (3) @(negedge clk);
        send(1, {16'h1234, 8'h33, 8'hCC}, 32);
        repeat (2) @(negedge clk);
        chk("filt_reject_error", 32'(e1), 32'(1));
        chk("filt_reject_ready", 32'(r1), 32'(0));
        @(negedge clk);
        chk("filt_error_one_cycle", 32'(e1), 32'(0));

        send(2, {16'h0000, 8'hA5, 4'h6, 4'h9}, 16);
        repeat (2) @(negedge clk);
        chk("narrow_tecla", 32'(t2), 32'(4'h6));
        chk("narrow_custom", 32'(c2), 32'(8'hA5));
        chk("narrow_ready", 32'(r2), 32'(1));
        repeat (3) @(negedge clk);
        send(2, {16'h0000, 8'hA5, 4'h6, 4'h6}, 16);
        repeat (2) @(negedge clk);
        chk("narrow_error", 32'(e2), 32'(1));
        chk("narrow_ready_low", 32'(r2), 32'(0));
        chk("narrow_tecla_kept", 32'(t2), 32'(4'h6));

        // reset in the middle of a frame, after 10 data bits
        run0(16'hFFFF, 8'h77, 8'h88, 3);
        @(negedge clk); ser0 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); ser0 = 1'($urandom_range(0, 1));
        end
        #2 rst = 1'b1;
        #1;
        chk("async_rst_tecla", 32'(t0), 32'(0));
        chk("async_rst_custom", 32'(c0), 32'(0));
        chk("async_rst_ready", 32'(r0), 32'(0));
        chk("async_rst_repeat", 32'(p0), 32'(0));
        chk("async_rst_count", 32'(n0), 32'(0));
        ser0 = 1'b1;
        model_reset();
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        run0(16'hFFFF, 8'h77, 8'h88, 0);
        run0(16'hABCD, 8'h3C, 8'hC3, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/remote_controller_rx.md
Name: remote_controller_rx

Overview:
- Parametrised successor of the 32-bit remote-control serial receiver.
- Deframes one-bit-per-clock serial frames: start bit, then custom code, key, inverted key.
- Validates each frame and can filter by custom (device) code.
- Reports the key, the custom code, an error pulse, and repeat presses with a saturating counter, for the keypad/display logic downstream.

Parameters:
- CUSTOM_W, 16: custom-code width in bits (>=1).
- KEY_W, 8: key-code width in bits (>=1); frame length FRAME_W = CUSTOM_W + 2*KEY_W.
- FILTER_EN, 0: 1 = reject frames whose custom code differs from CUSTOM_ID.
- CUSTOM_ID, 16'hFFFF: accepted custom code when FILTER_EN=1 (CUSTOM_W bits).
- REPEAT_WIN, 64: max clocks from the previous valid frame's Ready rise to the next valid frame's CHECK for it to count as a repeat.
- CNT_W, 8: RepeatCount width.

Ports:
- Clock, input, 1: system clock, rising edge. One serial bit per clock.
- Reset, input, 1: asynchronous, active-high reset.
- Serial, input, 1: serial line. Idles high; start bit is low.
- Tecla, output, KEY_W: last validated key code.
- Custom, output, CUSTOM_W: custom code of the last validated frame.
- Ready, output, 1: high while Tecla/Custom hold a valid frame.
- Error, output, 1: one-cycle pulse on a rejected frame.
- Repeat, output, 1: high with Ready when the held frame is a repeat.
- RepeatCount, output, CNT_W: consecutive repeats of the current key, saturating at all-ones.

Behaviour:
- Reset (async, any state): FSM to IDLE; shift register and bit counter cleared. Tecla=0, Custom=0, Ready=0, Error=0, Repeat=0, RepeatCount=0; window counter expired, last-frame registers 0.
- All Serial sampling is on the Clock rising edge.
- IDLE: Serial=0 sampled -> DATA, bit counter=0, Ready and Repeat cleared on that edge. Tecla, Custom and RepeatCount are held.
- DATA: shift Serial into a FRAME_W shift register, MSB first. After FRAME_W bits are sampled -> CHECK. The frame cannot be aborted by line level; only Reset aborts.
- Field split: bits [FRAME_W-1:2*KEY_W] = custom; [2*KEY_W-1:KEY_W] = key; [KEY_W-1:0] = inverted key.
- CHECK (one cycle) -> frame valid iff key == ~inverted key AND (FILTER_EN=0 OR custom == CUSTOM_ID).
  - Valid: Tecla, Custom loaded; Ready=1 at the end of the CHECK cycle. Latency is 2 clocks from the edge sampling the last data bit to Ready high.
  - Repeat=1 iff a valid frame with identical key and custom was recorded AND the window counter has not expired. Then RepeatCount += 1 (saturate); else RepeatCount=0, Repeat=0.
  - Valid frame: last key/custom recorded; window counter reloaded to REPEAT_WIN.
  - Invalid: Error=1 for exactly one cycle. Ready stays 0; Tecla/Custom/RepeatCount unchanged; window counter unchanged.
  - CHECK always -> STOP.
- STOP: wait for Serial=1 sampled -> IDLE. A line stuck low holds STOP with no new frame and no error.
- A new start bit may be taken on the first IDLE cycle after STOP.
- Window counter: decrements every clock while nonzero and stops at 0 (expired). An invalid frame does not break a repeat chain.
- Ready stays high indefinitely until the next start bit or Reset.
- Valid frame with same key outside the window: not a repeat; RepeatCount=0.

Test Plan:
- Reset, then frames custom FFFF with keys 00, 01, 1A, B2, FF, 55, AA, C3 (defaults), 20 idle clocks apart -> each: Ready=1 two clocks after last bit, Tecla equals the key, Custom=FFFF, Error never set, Repeat=0.
- Start bit then 32 ones (key FF, inverted FF) while Ready high from the prior frame -> Ready drops at start bit, Error single pulse, Ready stays 0, Tecla keeps prior value.
- Key 1A sent three times back-to-back within 64 clocks -> RepeatCount 0,1,2; Repeat=0,1,1. Fourth send after 100 idle clocks -> Repeat=0, RepeatCount=0.
- FILTER_EN=1, CUSTOM_ID=16'h00FF: frame custom 00FF key 33 -> Ready, Tecla=33. Custom 1234 key 33 -> Error pulse, no Ready.
- CUSTOM_W=8, KEY_W=4: frame custom A5, key 6, inverted 9 (16 bits) -> Tecla=6, Custom=A5. Inverted 6 instead -> Error.
- Reset asserted mid-DATA at bit 10 -> all outputs 0 immediately (asynchronous). The next complete frame decodes correctly.
